ysyx_22051013_mem_arb: RTL and testbench

- Two-master, one-slave memory arbiter sitting directly downstream of the CPU core.
- Merges the IFU instruction-fetch port and the LSU load/store port onto one shared memory request/response bus.
- Exactly one transaction is outstanding at a time; each response is routed back to the master that issued it.
- Prerequisite for moving the core off combinational memory onto a multi-cycle bus.

---
 rtl/ysyx_22051013_arb_pkg.sv | 20 ++
 rtl/ysyx_22051013_arb_tmo.sv | 26 ++
 rtl/ysyx_22051013_mem_arb.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_22051013_mem_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051013_arb_pkg.sv
// Shared encodings and default widths for the IFU/LSU memory arbiter.
package ysyx_22051013_arb_pkg;

    localparam int unsigned ARB_ADDR_W      = 64;
    localparam int unsigned ARB_DATA_W      = 64;
    localparam int unsigned ARB_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StRsp   = 2'd2,
        StFlush = 2'd3
    } arb_state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnLs = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/ysyx_22051013_arb_tmo.sv
// Response timeout counter: cleared on RSP entry, counts stalled RSP cycles, saturates at LIMIT.
module ysyx_22051013_arb_tmo #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22051013_mem_arb.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one transaction outstanding at a time.
// Optional response timeout with FLUSH state under YSYX_22051013_ARB_TIMEOUT_EN.
module ysyx_22051013_mem_arb
    import ysyx_22051013_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ARB_ADDR_W,
    parameter int unsigned DATA_W      = ARB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    output logic                if_rsp_err,
    input  logic                ls_req_valid,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_wen,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_req_ready,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                ls_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              tmo_expired;

`ifdef YSYX_22051013_ARB_TIMEOUT_EN
    ysyx_22051013_arb_tmo #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == StReq && mem_req_ready),
        .en      (state_q == StRsp && !mem_rsp_valid),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        rsp_err       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On contention, grant whichever master was not served last.
                if (ls_req_valid && (!if_req_valid || last_q == OwnIf)) begin
                    ls_req_ready = 1'b1;
                    owner_d      = OwnLs;
                    last_d       = OwnLs;
                    addr_d       = ls_req_addr;
                    wen_d        = ls_req_wen;
                    wdata_d      = ls_req_wdata;
                    wstrb_d      = ls_req_wstrb;
                    state_d      = StReq;
                end else if (if_req_valid) begin
                    if_req_ready = 1'b1;
                    owner_d      = OwnIf;
                    last_d       = OwnIf;
                    addr_d       = if_req_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wstrb_d      = '0;
                    state_d      = StReq;
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
                mem_req_wen   = wen_q;
                mem_req_wdata = wdata_q;
                mem_req_wstrb = wstrb_q;
                if (mem_req_ready) state_d = StRsp;
            end
            StRsp: begin
                if (mem_rsp_valid) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_rsp_data;
                    rsp_err   = mem_rsp_err;
                    state_d   = StIdle;
                end else if (tmo_expired) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = StFlush;
                end else begin
                    rsp_data = mem_rsp_data;
                    rsp_err  = mem_rsp_err;
                end
            end
            StFlush: begin
                if (mem_rsp_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are silent during the reset cycle regardless of the state being left.
        if (rst) begin
            if_req_ready  = 1'b0;
            ls_req_ready  = 1'b0;
            mem_req_valid = 1'b0;
            mem_req_addr  = '0;
            mem_req_wen   = 1'b0;
            mem_req_wdata = '0;
            mem_req_wstrb = '0;
            rsp_valid     = 1'b0;
            rsp_data      = '0;
            rsp_err       = 1'b0;
        end
    end

    assign if_rsp_valid = rsp_valid && (owner_q == OwnIf);
    assign if_rsp_data  = (owner_q == OwnIf) ? rsp_data : '0;
    assign if_rsp_err   = rsp_err && (owner_q == OwnIf);
    assign ls_rsp_valid = rsp_valid && (owner_q == OwnLs);
    assign ls_rsp_data  = (owner_q == OwnLs) ? rsp_data : '0;
    assign ls_rsp_err   = rsp_err && (owner_q == OwnLs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= OwnIf;
            last_q  <= OwnIf;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_mem_arb.sv
// Self-checking bench for ysyx_22051013_mem_arb; the timeout sequence runs only when
// YSYX_22051013_ARB_TIMEOUT_EN is defined.
module tb_ysyx_22051013_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [63:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_wen, ls_req_ready, ls_rsp_valid, ls_rsp_err;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic [7:0]  ls_req_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_err;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [7:0]  mem_req_wstrb;

    always #5 clk = ~clk;

    ysyx_22051013_mem_arb #(
        .ADDR_W      (64),
        .DATA_W      (64),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .if_rsp_err    (if_rsp_err),
        .ls_req_valid  (ls_req_valid),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wen    (ls_req_wen),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wstrb  (ls_req_wstrb),
        .ls_req_ready  (ls_req_ready),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_data   (ls_rsp_data),
        .ls_rsp_err    (ls_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err)
    );

    typedef struct {
        bit          is_ls;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          req_wait;
        int          rsp_wait;
        logic [63:0] rdata;
        logic        rerr;
        logic        exp_wen;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_exp_t;

    typedef struct {
        bit          is_ls;
        bit          chk_data;
        logic [63:0] data;
        logic        err;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    vec_t     vecs[6];
    int       checks = 0;
    int       errors = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        logic [63:0] ctl, dat;
        ctl = 64'({if_req_ready, ls_req_ready, mem_req_valid, mem_req_wen, mem_req_wstrb,
                   if_rsp_valid, if_rsp_err, ls_rsp_valid, ls_rsp_err});
        dat = mem_req_addr | mem_req_wdata | if_rsp_data | ls_rsp_data;
        check(ctl == 64'd0, {name, "_ctl"}, ctl, 64'd0);
        check(dat == 64'd0, {name, "_data"}, dat, 64'd0);
    endtask

    task automatic push_req(input vec_t v);
        req_exp_t e;
        e.addr  = v.addr;
        e.wen   = v.exp_wen;
        e.wdata = v.wdata;
        e.wstrb = v.exp_wstrb;
        req_q.push_back(e);
    endtask

    task automatic push_rsp(input bit is_ls, input bit chk_data, input logic [63:0] data,
                            input logic err);
        rsp_exp_t e;
        e.is_ls    = is_ls;
        e.chk_data = chk_data;
        e.data     = data;
        e.err      = err;
        rsp_q.push_back(e);
    endtask

    task automatic drive_req(input vec_t v);
        if (v.is_ls) begin
            ls_req_valid = 1'b1;
            ls_req_addr  = v.addr;
            ls_req_wen   = v.wen;
            ls_req_wdata = v.wdata;
            ls_req_wstrb = v.wstrb;
        end else begin
            if_req_valid = 1'b1;
            if_req_addr  = v.addr;
        end
    endtask

    task automatic release_req(input bit is_ls);
        if (is_ls) begin
            ls_req_valid = 1'b0;
            ls_req_wen   = 1'b0;
            ls_req_wdata = '0;
            ls_req_wstrb = '0;
        end else begin
            if_req_valid = 1'b0;
        end
    endtask

    task automatic wait_grant(input bit is_ls, output int lat);
        bit ok;
        lat = 0;
        @(negedge clk);
        while (!(is_ls ? ls_req_ready : if_req_ready) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        ok = is_ls ? ls_req_ready : if_req_ready;
        check(ok, "grant_timeout", 64'(ok), 64'd1);
    endtask

    // Entered at posedge+1 of the first REQ cycle; leaves at posedge+1 of the next IDLE cycle.
    task automatic bus_serve(input vec_t v);
        mem_req_ready = (v.req_wait == 0);
        mem_rsp_valid = (v.req_wait > 0);  // stray response while in REQ must be ignored
        mem_rsp_data  = 64'hBAD0_BAD0;
        for (int k = 0; k <= v.req_wait; k++) begin
            @(negedge clk);
            check(mem_req_valid, "req_valid", 64'(mem_req_valid), 64'd1);
            check(mem_req_addr == v.addr && mem_req_wen == v.exp_wen &&
                  mem_req_wstrb == v.exp_wstrb, "req_hold", mem_req_addr, v.addr);
            check(!if_req_ready && !ls_req_ready, "ready_busy",
                  64'({if_req_ready, ls_req_ready}), 64'd0);
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            if (k + 1 == v.req_wait) mem_req_ready = 1'b1;
        end
        mem_req_ready = 1'b0;
        repeat (v.rsp_wait) begin
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = v.rdata;
        mem_rsp_err   = v.rerr;
        push_rsp(v.is_ls, !v.exp_wen, v.exp_data, v.exp_err);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        int lat;
        @(posedge clk); #1;
        drive_req(v);
        wait_grant(v.is_ls, lat);
        check(lat == 0, "grant_lat", 64'(lat), 64'd0);
        push_req(v);
        @(posedge clk); #1;
        release_req(v.is_ls);
        bus_serve(v);
    endtask

    always @(negedge clk) begin : monitor
        req_exp_t re;
        rsp_exp_t se;
        logic [63:0] act_data;
        logic        act_err;
        if (mem_req_valid && mem_req_ready) begin
            if (req_q.size() == 0) begin
                check(1'b0, "unexpected_req", mem_req_addr, 64'd0);
            end else begin
                re = req_q.pop_front();
                check(mem_req_addr == re.addr, "req_addr", mem_req_addr, re.addr);
                check(mem_req_wen == re.wen, "req_wen", 64'(mem_req_wen), 64'(re.wen));
                check(mem_req_wstrb == re.wstrb, "req_wstrb", 64'(mem_req_wstrb),
                      64'(re.wstrb));
                if (re.wen) check(mem_req_wdata == re.wdata, "req_wdata", mem_req_wdata, re.wdata);
            end
        end
        if (if_rsp_valid && ls_rsp_valid) begin
            check(1'b0, "dual_rsp", 64'd3, 64'd1);
        end else if (if_rsp_valid || ls_rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check(1'b0, "unexpected_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
            end else begin
                se       = rsp_q.pop_front();
                act_data = ls_rsp_valid ? ls_rsp_data : if_rsp_data;
                act_err  = ls_rsp_valid ? ls_rsp_err : if_rsp_err;
                check(ls_rsp_valid == se.is_ls, "rsp_port", 64'(ls_rsp_valid), 64'(se.is_ls));
                if (se.chk_data) check(act_data == se.data, "rsp_data", act_data, se.data);
                check(act_err == se.err, "rsp_err", 64'(act_err), 64'(se.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v_ls, v_if, v_ls2, v_rst, v_to, v_after;
        int   lat;

        //          ls  addr              wen  wdata                  strb   rq ro rdata                  rerr ewen estrb  edata                  eerr
        vecs[0] = '{0, 64'h8000_0000, 1'b0, 64'h0,                 8'h00, 0, 0, 64'h13,                1'b0, 1'b0, 8'h00, 64'h13,                1'b0};
        vecs[1] = '{1, 64'h8000_2000, 1'b1, 64'hDEAD_BEEF,         8'h0F, 4, 1, 64'h5A5A,              1'b0, 1'b1, 8'h0F, 64'h0,                 1'b0};
        vecs[2] = '{0, 64'h8000_0008, 1'b0, 64'h0,                 8'h00, 1, 2, 64'hFFFF,              1'b1, 1'b0, 8'h00, 64'hFFFF,              1'b1};
        vecs[3] = '{0, 64'h8000_000C, 1'b0, 64'h0,                 8'h00, 0, 0, 64'h0010_0093,         1'b0, 1'b0, 8'h00, 64'h0010_0093,         1'b0};
        vecs[4] = '{1, 64'h8000_1008, 1'b0, 64'h1111,              8'h00, 2, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[5] = '{1, 64'h8000_3000, 1'b1, 64'hCAFE_F00D_1234_5678, 8'hF0, 0, 3, 64'h0,               1'b1, 1'b1, 8'hF0, 64'h0,                 1'b1};

        v_ls    = '{1, 64'h8000_1000, 1'b0, 64'h0, 8'h00, 0, 0, 64'hAAAA_5555, 1'b0, 1'b0, 8'h00, 64'hAAAA_5555, 1'b0};
        v_if    = '{0, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 0, 1, 64'h0000_0513, 1'b0, 1'b0, 8'h00, 64'h0000_0513, 1'b0};
        v_ls2   = '{1, 64'h8000_1010, 1'b0, 64'h0, 8'h00, 1, 0, 64'h7777_8888, 1'b0, 1'b0, 8'h00, 64'h7777_8888, 1'b0};
        v_rst   = '{0, 64'h8000_0100, 1'b0, 64'h0, 8'h00, 0, 0, 64'h0,         1'b0, 1'b0, 8'h00, 64'h0,         1'b0};
        v_to    = '{1, 64'h8000_4000, 1'b0, 64'h0, 8'h00, 0, 0, 64'h0,         1'b0, 1'b0, 8'h00, 64'h0,         1'b1};
        v_after = '{0, 64'h8000_0200, 1'b0, 64'h0, 8'h00, 0, 0, 64'h1234,      1'b0, 1'b0, 8'h00, 64'h1234,      1'b0};

        rst = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
        ls_req_valid = 1'b1; ls_req_addr = 64'h8000_1000;
        ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wstrb = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'h77; mem_rsp_err = 1'b0;

        @(negedge clk);
        check_quiet("reset_quiet");
        @(posedge clk); #1;
        rst = 1'b0;
        release_req(1'b0);
        release_req(1'b1);
        mem_rsp_data = '0;

        // Contention straight out of reset: LS wins, then alternation hands the next slot to IF.
        @(posedge clk); #1;
        drive_req(v_ls);
        drive_req(v_if);
        @(negedge clk);
        check(ls_req_ready && !if_req_ready, "arb_ls_first",
              64'({if_req_ready, ls_req_ready}), 64'd1);
        push_req(v_ls);
        @(posedge clk); #1;
        release_req(1'b1);
        bus_serve(v_ls);
        drive_req(v_ls2);
        @(negedge clk);
        check(if_req_ready && !ls_req_ready, "arb_alternate_if",
              64'({if_req_ready, ls_req_ready}), 64'd2);
        push_req(v_if);
        @(posedge clk); #1;
        release_req(1'b0);
        bus_serve(v_if);
        @(negedge clk);
        check(ls_req_ready, "arb_ls_pending", 64'(ls_req_ready), 64'd1);
        push_req(v_ls2);
        @(posedge clk); #1;
        release_req(1'b1);
        bus_serve(v_ls2);

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Reset while waiting for a response: nothing may reach either master.
        @(posedge clk); #1;
        drive_req(v_rst);
        wait_grant(1'b0, lat);
        push_req(v_rst);
        @(posedge clk); #1;
        release_req(1'b0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        mem_rsp_data = 64'h77;
        mem_rsp_err  = 1'b1;
        @(negedge clk);
        check_quiet("reset_in_rsp");
        @(posedge clk); #1;
        rst = 1'b0;
        release_req(1'b0);
        release_req(1'b1);
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        check(!mem_req_valid && !if_rsp_valid && !ls_rsp_valid, "late_rsp_ignored",
              64'({mem_req_valid, if_rsp_valid, ls_rsp_valid}), 64'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        do_txn(vecs[3]);

`ifdef YSYX_22051013_ARB_TIMEOUT_EN
        @(posedge clk); #1;
        drive_req(v_to);
        wait_grant(1'b1, lat);
        push_req(v_to);
        @(posedge clk); #1;
        release_req(1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        push_rsp(1'b1, 1'b1, 64'd0, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        drive_req(v_after);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h99;
        @(negedge clk);
        check(!if_req_ready && !ls_req_ready, "flush_ready",
              64'({if_req_ready, ls_req_ready}), 64'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        wait_grant(1'b0, lat);
        check(lat == 0, "grant_after_flush", 64'(lat), 64'd0);
        push_req(v_after);
        @(posedge clk); #1;
        release_req(1'b0);
        bus_serve(v_after);
`endif

        repeat (3) @(posedge clk);
        check(req_q.size() == 0, "req_q_drained", 64'(req_q.size()), 64'd0);
        check(rsp_q.size() == 0, "rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
